// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one pipelined CORDIC between NREQ requesters.
// Round-robin issue, ID-tag pipeline, credit-gated FWFT response FIFO.
// Ports: clock/reset_n; req_valid/req_angle/req_ready (requesters);
// cordic_x_start/y_start/angle out, cordic_cosine/sine in (rotator);
// rsp_valid/rsp_ready/rsp_id/rsp_cos/rsp_sin (FIFO head); busy.
// Option: CORDIC_ARB_PRIO0_EN gives requester 0 fixed priority.
module cordic_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 20,
  parameter int OUTW       = 32,
  parameter int LATENCY    = 20,
  parameter int FIFO_DEPTH = 32,
  parameter int X_INIT     = 39797
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [32*NREQ-1:0]       req_angle,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         cordic_x_start,
  output logic [WIDTH-1:0]         cordic_y_start,
  output logic [31:0]              cordic_angle,
  input  logic [OUTW-1:0]          cordic_cosine,
  input  logic [OUTW-1:0]          cordic_sine,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [OUTW-1:0]          rsp_cos,
  output logic [OUTW-1:0]          rsp_sin,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = IDW + 2 * OUTW;

  logic [IDW-1:0]     rr_q, rr_d;
  logic [CW-1:0]      cred_q, cred_d;
  logic [LATENCY-1:0] tv_q;
  logic [IDW-1:0]     tid_q [LATENCY];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [EW-1:0]      head;

  logic           gnt_v;
  logic [IDW-1:0] gnt_id;
  logic           rr_mv;
  logic [IDW:0]   cand;
  logic           issue;
  logic           wr;
  logic           pop;

  // Search from rr_q+1 with wrap; cand is one bit wider so the
  // modulo-NREQ wrap works for non-power-of-2 NREQ.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    rr_mv  = 1'b0;
    cand   = '0;
`ifdef CORDIC_ARB_PRIO0_EN
    if (req_valid[0]) gnt_v = 1'b1;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
`ifdef CORDIC_ARB_PRIO0_EN
      if (!gnt_v && cand != '0 &&
          req_valid[cand[IDW-1:0]]) begin
`else
      if (!gnt_v && req_valid[cand[IDW-1:0]]) begin
`endif
        gnt_v  = 1'b1;
        gnt_id = cand[IDW-1:0];
        rr_mv  = 1'b1;
      end
    end
  end

  assign issue = gnt_v & (cred_q != '0) & reset_n;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    cordic_angle = '0;
    for (int k = 0; k < NREQ; k++)
      if (issue && gnt_id == IDW'(k))
        cordic_angle = req_angle[32*k +: 32];
  end

  assign cordic_x_start = WIDTH'(X_INIT);
  assign cordic_y_start = '0;

  assign wr        = tv_q[LATENCY-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;

  assign cnt_d  = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
  assign cred_d = cred_q - CW'(issue) + CW'(pop);
  assign rr_d   = (issue && rr_mv) ? gnt_id : rr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_q   <= IDW'(NREQ - 1);
      cred_q <= CW'(FIFO_DEPTH);
      tv_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      cred_q <= cred_d;
      tv_q   <= {tv_q[LATENCY-2:0], issue};
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q  <= cnt_d;
    end
  end

  // IDs and FIFO storage are qualified by tv_q / cnt_q, so no reset.
  always_ff @(posedge clock) begin
    tid_q[0] <= gnt_id;
    for (int k = 1; k < LATENCY; k++)
      tid_q[k] <= tid_q[k-1];
    if (wr)
      mem_q[wptr_q] <= {tid_q[LATENCY-1], cordic_cosine, cordic_sine};
  end

  assign head    = mem_q[rptr_q];
  assign rsp_id  = rsp_valid ? head[EW-1 -: IDW] : '0;
  assign rsp_cos = rsp_valid ? head[2*OUTW-1 -: OUTW] : '0;
  assign rsp_sin = rsp_valid ? head[OUTW-1:0] : '0;
  assign busy    = (|tv_q) | rsp_valid;

endmodule
